// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: issues loads/stores to the data bus, stalls upstream
// while a transaction is outstanding, and registers the write-back result.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [5:0]  ID_LB  = 6'd11,
  parameter logic [5:0]  ID_LH  = 6'd12,
  parameter logic [5:0]  ID_LW  = 6'd13,
  parameter logic [5:0]  ID_LBU = 6'd14,
  parameter logic [5:0]  ID_LHU = 6'd15,
  parameter logic [5:0]  ID_SB  = 6'd16,
  parameter logic [5:0]  ID_SH  = 6'd17,
  parameter logic [5:0]  ID_SW  = 6'd18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [5:0]   instr_id_in,
  input  logic [31:0]  mem_addr_in,
  input  logic [31:0]  rs2_value_in,
  input  logic [31:0]  exec_output_in,
  input  logic [4:0]   rd_addr_in,
  input  logic         rd_valid_in,
  output logic         stall_out,
  mem_access_unit_if.master dmem,
  output logic [31:0]  wb_data_out,
  output logic [4:0]   rd_addr_out,
  output logic         rd_valid_out,
  output logic         valid_out,
  output logic         misalign_out,
  output logic         bus_err_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state;
  logic [7:0]  wait_cnt;
  logic [5:0]  id_q;
  logic [1:0]  lane_q;

  logic        is_load, is_store, is_mem, misaligned, issue, ack_busy, timeout;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load    = (instr_id_in == ID_LB)  || (instr_id_in == ID_LH) || (instr_id_in == ID_LW) ||
                 (instr_id_in == ID_LBU) || (instr_id_in == ID_LHU);
    is_store   = (instr_id_in == ID_SB)  || (instr_id_in == ID_SH) || (instr_id_in == ID_SW);
    is_mem     = valid_in && (is_load || is_store);
    misaligned = (((instr_id_in == ID_LH) || (instr_id_in == ID_LHU) || (instr_id_in == ID_SH))
                   && mem_addr_in[0]) ||
                 (((instr_id_in == ID_LW) || (instr_id_in == ID_SW)) && (mem_addr_in[1:0] != 2'b00));
    issue      = (state == IDLE) && is_mem && !misaligned;
    ack_busy   = (state == BUSY) && dmem.dmem_ack;
    timeout    = (state == BUSY) && !dmem.dmem_ack && (wait_cnt == WAIT_LAST);
    // Reset gating keeps the upstream register free while rst is held with a live op.
    stall_out  = !rst && (issue || ((state == BUSY) && !dmem.dmem_ack && !timeout));
  end

  always_comb begin
    st_wdata = rs2_value_in;
    st_wstrb = 4'b0000;
    if (instr_id_in == ID_SB) begin
      st_wdata = {4{rs2_value_in[7:0]}};
      st_wstrb = 4'b0001 << mem_addr_in[1:0];
    end else if (instr_id_in == ID_SH) begin
      st_wdata = {2{rs2_value_in[15:0]}};
      st_wstrb = mem_addr_in[1] ? 4'b1100 : 4'b0011;
    end else if (instr_id_in == ID_SW) begin
      st_wstrb = 4'b1111;
    end
  end

  // Lane selection uses the op/offset captured at issue, not the live inputs.
  always_comb begin
    ld_byte = 8'(dmem.dmem_rdata >> {lane_q, 3'b000});
    ld_half = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    ld_data = dmem.dmem_rdata;
    if (id_q == ID_LB)       ld_data = {{24{ld_byte[7]}}, ld_byte};
    else if (id_q == ID_LBU) ld_data = {24'd0, ld_byte};
    else if (id_q == ID_LH)  ld_data = {{16{ld_half[15]}}, ld_half};
    else if (id_q == ID_LHU) ld_data = {16'd0, ld_half};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      id_q            <= '0;
      lane_q          <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_wstrb <= '0;
    end else if (issue) begin
      state           <= BUSY;
      wait_cnt        <= '0;
      id_q            <= instr_id_in;
      lane_q          <= mem_addr_in[1:0];
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= is_store;
      dmem.dmem_addr  <= {mem_addr_in[31:2], 2'b00};
      dmem.dmem_wdata <= is_store ? st_wdata : '0;
      dmem.dmem_wstrb <= st_wstrb;
    end else if (ack_busy || timeout) begin
      state         <= IDLE;
      dmem.dmem_req <= 1'b0;
    end else if (state == BUSY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_out  <= '0;
      rd_addr_out  <= '0;
      rd_valid_out <= 1'b0;
      valid_out    <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else if (stall_out) begin
      valid_out    <= 1'b0;
      rd_valid_out <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      valid_out    <= valid_in;
      rd_addr_out  <= rd_addr_in;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      if (ack_busy) begin
        if (dmem.dmem_we) begin
          rd_valid_out <= 1'b0;
        end else begin
          wb_data_out  <= ld_data;
          rd_valid_out <= rd_valid_in;
        end
      end else if (timeout) begin
        bus_err_out  <= 1'b1;
        rd_valid_out <= 1'b0;
      end else if (is_mem && misaligned) begin
        misalign_out <= 1'b1;
        rd_valid_out <= 1'b0;
      end else begin
        wb_data_out  <= exec_output_in;
        rd_valid_out <= rd_valid_in && valid_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a result scoreboard on the write-back port.
module tb_mem_access_unit;

  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [5:0]  instr_id_in = '0;
  logic [31:0] mem_addr_in = '0, rs2_value_in = '0, exec_output_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        rd_valid_in = 1'b0;
  logic        stall_out, rd_valid_out, valid_out, misalign_out, bus_err_out;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_addr_out;

  mem_access_unit_if dmem_bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_id_in(instr_id_in),
    .mem_addr_in(mem_addr_in), .rs2_value_in(rs2_value_in), .exec_output_in(exec_output_in),
    .rd_addr_in(rd_addr_in), .rd_valid_in(rd_valid_in), .stall_out(stall_out),
    .dmem(dmem_bus), .wb_data_out(wb_data_out), .rd_addr_out(rd_addr_out),
    .rd_valid_out(rd_valid_out), .valid_out(valid_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic        chk_wb;
    logic [4:0]  rd;
    logic        rdv;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] wb, input logic chk_wb, input logic [4:0] rd,
                      input logic rdv, input logic mis, input logic berr);
    exp_t e;
    e.wb = wb; e.chk_wb = chk_wb; e.rd = rd; e.rdv = rdv; e.mis = mis; e.berr = berr;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (valid_out) begin
      if (sb.size() == 0) begin
        chk("sb_spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_wb) chk("wb_data", wb_data_out, e.wb);
        chk("rd_addr", 32'(rd_addr_out), 32'(e.rd));
        chk("rd_valid", 32'(rd_valid_out), 32'(e.rdv));
        chk("misalign", 32'(misalign_out), 32'(e.mis));
        chk("bus_err", 32'(bus_err_out), 32'(e.berr));
      end
    end else begin
      chk("bubble_quiet", {29'd0, misalign_out, bus_err_out, rd_valid_out}, 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic set_in(input logic v, input logic [5:0] id, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] ex,
                        input logic [4:0] rd, input logic rdv);
    valid_in = v; instr_id_in = id; mem_addr_in = addr; rs2_value_in = rs2;
    exec_output_in = ex; rd_addr_in = rd; rd_valid_in = rdv;
  endtask

  // Aligned load/store with the ack arriving in BUSY cycle ack_cyc (1 = first).
  task automatic mem_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input logic [4:0] rd, input int unsigned ack_cyc,
                        input logic [31:0] exp_wb, input logic is_st,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    set_in(1'b1, id, addr, rs2, 32'h0, rd, 1'b1);
    #1;
    chk("issue_stall", 32'(stall_out), 32'd1);
    push(exp_wb, !is_st, rd, !is_st, 1'b0, 1'b0);
    tick();
    chk("req_high", 32'(dmem_bus.dmem_req), 32'd1);
    chk("req_addr", dmem_bus.dmem_addr, {addr[31:2], 2'b00});
    chk("req_we", 32'(dmem_bus.dmem_we), 32'(is_st));
    if (is_st) begin
      chk("req_wstrb", 32'(dmem_bus.dmem_wstrb), 32'(exp_strb));
      chk("req_wdata", dmem_bus.dmem_wdata, exp_wdata);
    end
    for (int unsigned i = 1; i < ack_cyc; i++) begin
      chk("wait_stall", 32'(stall_out), 32'd1);
      tick();
      chk("wait_req_addr", dmem_bus.dmem_addr, {addr[31:2], 2'b00});
    end
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = rdata;
    #1;
    chk("ack_stall_release", 32'(stall_out), 32'd0);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    set_in(1'b0, ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("req_dropped", 32'(dmem_bus.dmem_req), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mis_addr [3];
    logic [5:0]  mis_id [3];
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_wb", wb_data_out, 32'd0);
    chk("rst_wstrb", 32'(dmem_bus.dmem_wstrb), 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back non-memory ops: one-cycle latency, no stall
    set_in(1'b1, ADD, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 1'b1);
    #1; chk("add_no_stall", 32'(stall_out), 32'd0);
    push(32'h0000_1234, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, ADD, 32'h0, 32'h0, 32'hDEAD_0001, 5'd6, 1'b0);
    #1; chk("add2_no_stall", 32'(stall_out), 32'd0);
    push(32'hDEAD_0001, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1; chk("add_drained", 32'(sb.size()), 32'd0);
    tick();

    // Loads and stores
    mem_op(LB,  32'h0000_0103, 32'h0, 32'h80FF_FFFF, 5'd7,  3, 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0);
    mem_op(SH,  32'h0000_0202, 32'hABCD_1234, 32'h0, 5'd3, 1, 32'h0, 1'b1, 4'b1100, 32'h1234_1234);
    mem_op(LHU, 32'h0000_0302, 32'h0, 32'h8001_7FFF, 5'd8,  1, 32'h0000_8001, 1'b0, 4'h0, 32'h0);
    mem_op(LH,  32'h0000_0300, 32'h0, 32'h1234_8765, 5'd12, 2, 32'hFFFF_8765, 1'b0, 4'h0, 32'h0);
    mem_op(LBU, 32'h0000_0101, 32'h0, 32'h0000_A500, 5'd13, 1, 32'h0000_00A5, 1'b0, 4'h0, 32'h0);
    mem_op(SB,  32'h0000_0011, 32'h1111_115A, 32'h0, 5'd14, 2, 32'h0, 1'b1, 4'b0010, 32'h5A5A_5A5A);
    mem_op(SW,  32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 5'd15, 1, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    // Ack on the final permitted cycle wins over the timeout
    mem_op(LW,  32'h0000_0044, 32'h0, 32'hCAFE_BABE, 5'd10, 4, 32'hCAFE_BABE, 1'b0, 4'h0, 32'h0);
    tick();

    // Misaligned ops never reach the bus
    mis_addr[0] = 32'h0000_0002; mis_id[0] = LW;
    mis_addr[1] = 32'h0000_0101; mis_id[1] = LH;
    mis_addr[2] = 32'h0000_0003; mis_id[2] = SW;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, mis_id[i], mis_addr[i], 32'h0, 32'h0, 5'(20 + i), 1'b1);
      #1; chk("mis_no_stall", 32'(stall_out), 32'd0);
      push(32'h0, 1'b0, 5'(20 + i), 1'b0, 1'b1, 1'b0);
      tick();
      chk("mis_no_req", 32'(dmem_bus.dmem_req), 32'd0);
      set_in(1'b0, ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
    end
    chk("mis_drained", 32'(sb.size()), 32'd0);

    // Timeout after 4 BUSY cycles without ack
    set_in(1'b1, LW, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 1'b1);
    #1; chk("to_issue_stall", 32'(stall_out), 32'd1);
    push(32'h0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_req", 32'(dmem_bus.dmem_req), 32'd1);
      chk("to_wait_stall", 32'(stall_out), 32'd1);
      tick();
    end
    chk("to_last_req", 32'(dmem_bus.dmem_req), 32'd1);
    chk("to_stall_release", 32'(stall_out), 32'd0);
    tick();
    set_in(1'b0, ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("to_req_dropped", 32'(dmem_bus.dmem_req), 32'd0);
    chk("to_drained", 32'(sb.size()), 32'd0);
    tick();

    // Ack while idle is ignored
    dmem_bus.dmem_ack = 1'b1;
    #1; chk("idle_ack_stall", 32'(stall_out), 32'd0);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    chk("idle_ack_no_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("idle_ack_no_valid", 32'(valid_out), 32'd0);

    // Reset in the middle of a transaction
    set_in(1'b1, LW, 32'h0000_0050, 32'h0, 32'h0, 5'd11, 1'b1);
    tick();
    chk("mid_req_high", 32'(dmem_bus.dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);
    chk("mid_rst_addr", dmem_bus.dmem_addr, 32'd0);
    chk("mid_rst_wb", wb_data_out, 32'd0);
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    set_in(1'b0, ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
